fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// - Owns the instruction address and sequences every PC update for the single-issue core.
// - Gates PC advance on instruction- and data-memory BUSYWAIT.
// - Latches a branch/jump redirect that arrives during a stall and applies it once the stall clears.
// - Flags misaligned targets and stall timeouts.
// - Sits between the PC incrementer/branch logic and instruction memory; drives IMEM address and read strobe.
// PARAMETERS
// - ADDR_WIDTH      32   PC width in bits.
// - RESET_VECTOR    0    PC value loaded on RESET.
// - STALL_TIMEOUT   255  Max consecutive stall cycles before TIMEOUT_ERR; range 1..2^16-1.
// PORTS
// - CLK              in   1           Clock, rising edge.
// - RESET            in   1           Asynchronous, active-high reset.
// - IMEM_BUSYWAIT    in   1           Instruction memory not ready.
// - DMEM_BUSYWAIT    in   1           Data memory not ready; stalls fetch.
// - REDIRECT         in   1           Branch taken or jump, resolved this cycle.
// - REDIRECT_TARGET  in   ADDR_WIDTH  Target address for REDIRECT.
// - PC_OUT           out  ADDR_WIDTH  Current instruction address.
// - IMEM_READ        out  1           Instruction read strobe.
// - FETCH_VALID      out  1           Instruction at PC_OUT is accepted this cycle.
// - STALL            out  1           PC held this cycle.
// - MISALIGN_ERR     out  1           Sticky: a target with [1:0]!=0 was seen.
// - TIMEOUT_ERR      out  1           Sticky: stall exceeded STALL_TIMEOUT.
// - RETIRED_COUNT    out  32          Accepted-fetch counter (optional feature).
// - STALL_COUNT      out  32          Stall-cycle counter (optional feature).
// BEHAVIOUR
// - Reset values:
//   - PC_OUT=RESET_VECTOR, state=BOOT, redirect latch empty.
//   - All 1-bit outputs 0; both counters 0.
// - Reset is effective immediately and mid-stall; it discards any pending redirect.
// - BOOT: IMEM_READ=0. Goes to FETCH on the next edge; PC unchanged.
// - FETCH: IMEM_READ=1; busy = IMEM_BUSYWAIT | DMEM_BUSYWAIT.
//   - busy=0: FETCH_VALID=1, STALL=0. Next edge loads PC:
//     - latched target if a redirect is pending, else
//     - REDIRECT_TARGET if REDIRECT=1, else
//     - PC_OUT+4.
//     Then stay in FETCH and clear the latch.
//   - busy=1: STALL=1, FETCH_VALID=0, PC held; go to HOLD. If REDIRECT=1, latch REDIRECT_TARGET.
// - HOLD: IMEM_READ=1, STALL=1, PC held.
//   - A REDIRECT in HOLD overwrites the latch; the latest redirect wins.
//   - When busy falls, behave exactly as FETCH with busy=0 in that same cycle: FETCH_VALID=1, next edge loads PC, go to FETCH.
// - Alignment:
//   - Every loaded target is forced to {target[ADDR_WIDTH-1:2],2'b00}.
//   - MISALIGN_ERR is set when the target had [1:0]!=0.
//   - Sequential PC+4 wraps modulo 2^ADDR_WIDTH without error.
// - Timeout:
//   - A 16-bit stall counter increments each cycle with STALL=1 and clears on any cycle with STALL=0.
//   - When it equals STALL_TIMEOUT, TIMEOUT_ERR sets. It stays set until RESET.
//   - The processor is not halted; PC still holds until busy clears.
// - Latency: PC updates 1 cycle after acceptance. There is no bubble after a redirect.
// CONFIGURATION
// - FETCH_PERF_CNT_EN defined:
//   - RETIRED_COUNT increments on each FETCH_VALID cycle.
//   - STALL_COUNT increments on each STALL cycle.
//   - Both are 32-bit, wrap at 2^32, and clear only on RESET.
// - FETCH_PERF_CNT_EN undefined: the counter logic is not built; RETIRED_COUNT and STALL_COUNT are tied to 0.
// TESTING
// 1. Sequential fetch and wrap:
//    - RESET, then no busy for 4 cycles -> PC_OUT 0,0(BOOT),4,8,12; FETCH_VALID 0,1,1,1.
//    - Preload PC 0xFFFFFFFC -> next PC 0x0.
// 2. Redirect while idle: REDIRECT=1, target 0x40 at PC 8 -> next PC 0x40; no bubble; MISALIGN_ERR=0.
// 3. Redirect during stall:
//    - IMEM_BUSYWAIT=1 for 3 cycles; REDIRECT 0x80 in cycle 1, 0x90 in cycle 2 -> PC held, STALL=1 for 3 cycles.
//    - After release -> PC=0x90.
// 4. Misaligned target 0x23 -> PC=0x20, MISALIGN_ERR=1 until RESET.
// 5. Timeout: STALL_TIMEOUT=4, DMEM_BUSYWAIT held 6 cycles -> TIMEOUT_ERR rises on 4th stall cycle and stays; PC held throughout.
// 6. Mid-stall reset and counters:
//    - RESET asserted in HOLD with a pending redirect -> PC=RESET_VECTOR; the pending redirect is not applied after reset.
//    - With FETCH_PERF_CNT_EN: 5 accepts + 3 stalls -> RETIRED_COUNT=5, STALL_COUNT=3.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of the sequencer: memory busy inputs, redirect request, and PC/strobe/status outputs.
// The master modport is the sequencer itself; the slave modport is the core/memory environment.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  IMEM_BUSYWAIT;
  logic                  DMEM_BUSYWAIT;
  logic                  REDIRECT;
  logic [ADDR_WIDTH-1:0] REDIRECT_TARGET;
  logic [ADDR_WIDTH-1:0] PC_OUT;
  logic                  IMEM_READ;
  logic                  FETCH_VALID;
  logic                  STALL;
  logic                  MISALIGN_ERR;
  logic                  TIMEOUT_ERR;
  logic [31:0]           RETIRED_COUNT;
  logic [31:0]           STALL_COUNT;

  modport master (
    input  IMEM_BUSYWAIT, DMEM_BUSYWAIT, REDIRECT, REDIRECT_TARGET,
    output PC_OUT, IMEM_READ, FETCH_VALID, STALL, MISALIGN_ERR, TIMEOUT_ERR,
           RETIRED_COUNT, STALL_COUNT
  );

  modport slave (
    output IMEM_BUSYWAIT, DMEM_BUSYWAIT, REDIRECT, REDIRECT_TARGET,
    input  PC_OUT, IMEM_READ, FETCH_VALID, STALL, MISALIGN_ERR, TIMEOUT_ERR,
           RETIRED_COUNT, STALL_COUNT
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner for the single-issue core: stall gating, deferred redirects, alignment and timeout flags.
// Define FETCH_PERF_CNT_EN to build the retired/stall performance counters (tied to 0 otherwise).
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int unsigned           STALL_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RESET,
  fetch_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(STALL_TIMEOUT);

  state_e                state_q, state_d;
  logic                  busy;
  logic                  imem_read, fetch_valid, stall;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_target_q;
  logic                  misalign_q;
  logic                  timeout_q;
  logic [15:0]           stall_run_q;
  logic                  take_target;
  logic [ADDR_WIDTH-1:0] target_sel;

  assign busy = bus.IMEM_BUSYWAIT | bus.DMEM_BUSYWAIT;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      BOOT:        state_d = FETCH;
      FETCH, HOLD: state_d = busy ? HOLD : FETCH;
      default:     state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_read   = 1'b0;
    fetch_valid = 1'b0;
    stall       = 1'b0;
    case (state_q)
      FETCH, HOLD: begin
        imem_read   = 1'b1;
        fetch_valid = ~busy;
        stall       = busy;
      end
      default: ;
    endcase
  end

  // A redirect captured during a stall outranks one arriving in the accept cycle.
  assign take_target = pend_q | bus.REDIRECT;
  assign target_sel  = pend_q ? pend_target_q : bus.REDIRECT_TARGET;

  // NOTE: the pending-target register is reset along with its valid bit so no stale address is observable.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q          <= RESET_VECTOR;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      misalign_q    <= 1'b0;
    end else if (fetch_valid) begin
      pend_q <= 1'b0;
      if (take_target) begin
        pc_q <= {target_sel[ADDR_WIDTH-1:2], 2'b00};
        if (target_sel[1:0] != 2'b00) misalign_q <= 1'b1;
      end else begin
        pc_q <= pc_q + ADDR_WIDTH'(4);
      end
    end else if (stall && bus.REDIRECT) begin
      pend_q        <= 1'b1;
      pend_target_q <= bus.REDIRECT_TARGET;
    end
  end

  // The flag sets on the edge that completes the STALL_TIMEOUT-th consecutive stall cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_run_q <= '0;
      timeout_q   <= 1'b0;
    end else if (stall) begin
      stall_run_q <= stall_run_q + 16'd1;
      if (stall_run_q + 16'd1 == TIMEOUT_LIMIT) timeout_q <= 1'b1;
    end else begin
      stall_run_q <= '0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt_q, stall_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (fetch_valid) retired_cnt_q <= retired_cnt_q + 32'd1;
      if (stall)       stall_cnt_q   <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.RETIRED_COUNT = retired_cnt_q;
  assign bus.STALL_COUNT   = stall_cnt_q;
`else
  assign bus.RETIRED_COUNT = 32'd0;
  assign bus.STALL_COUNT   = 32'd0;
`endif

  assign bus.PC_OUT       = pc_q;
  assign bus.IMEM_READ    = imem_read;
  assign bus.FETCH_VALID  = fetch_valid;
  assign bus.STALL        = stall;
  assign bus.MISALIGN_ERR = misalign_q;
  assign bus.TIMEOUT_ERR  = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against a transaction-level PC model.
// The model tracks redirects seen during a stall in a queue and applies the newest on acceptance.
module tb_fetch_sequencer;

  localparam int          AW      = 32;
  localparam int unsigned TIMEOUT = 4;

  logic CLK;
  logic RESET;

  fetch_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_sequencer #(
    .ADDR_WIDTH   (AW),
    .RESET_VECTOR ('0),
    .STALL_TIMEOUT(TIMEOUT)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_started;
  logic [31:0] m_redirects[$];
  bit          m_misalign;
  bit          m_timeout;
  int          m_run;
  logic [31:0] m_retired;
  logic [31:0] m_stalls;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic model_reset();
    m_pc      = 32'h0;
    m_started = 1'b0;
    m_redirects.delete();
    m_misalign = 1'b0;
    m_timeout  = 1'b0;
    m_run      = 0;
    m_retired  = 32'd0;
    m_stalls   = 32'd0;
  endtask

  task automatic check_all(input string tag, input bit busy);
    check({tag, ".pc"},       bus.PC_OUT,               m_pc);
    check({tag, ".read"},     32'(bus.IMEM_READ),       32'(m_started));
    check({tag, ".valid"},    32'(bus.FETCH_VALID),     32'(m_started && !busy));
    check({tag, ".stall"},    32'(bus.STALL),           32'(m_started && busy));
    check({tag, ".misalign"}, 32'(bus.MISALIGN_ERR),    32'(m_misalign));
    check({tag, ".timeout"},  32'(bus.TIMEOUT_ERR),     32'(m_timeout));
    check({tag, ".retired"},  bus.RETIRED_COUNT,        exp_cnt(m_retired));
    check({tag, ".stalls"},   bus.STALL_COUNT,          exp_cnt(m_stalls));
  endtask

  // Called right after a falling edge: drive, check mid-cycle, advance model, move to next falling edge.
  task automatic step(input string tag, input bit imem, input bit dmem, input bit redir,
                      input logic [31:0] target);
    logic [31:0] t;
    bit busy;
    busy = imem | dmem;
    bus.IMEM_BUSYWAIT   = imem;
    bus.DMEM_BUSYWAIT   = dmem;
    bus.REDIRECT        = redir;
    bus.REDIRECT_TARGET = target;
    #1;
    check_all(tag, busy);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!busy) begin
      m_retired++;
      m_run = 0;
      if (m_redirects.size() > 0 || redir) begin
        t = (m_redirects.size() > 0) ? m_redirects[$] : target;
        m_pc = t & 32'hFFFF_FFFC;
        if (t[1:0] != 2'b00) m_misalign = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_redirects.delete();
    end else begin
      m_stalls++;
      m_run++;
      if (m_run >= int'(TIMEOUT)) m_timeout = 1'b1;
      if (redir) m_redirects.push_back(target);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    bus.IMEM_BUSYWAIT   = 1'b0;
    bus.DMEM_BUSYWAIT   = 1'b0;
    bus.REDIRECT        = 1'b0;
    bus.REDIRECT_TARGET = 32'h0;
    RESET = 1'b1;
    #1;
    model_reset();
    m_started = 1'b0;
    check_all("reset", 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    bit          r_busy_i, r_busy_d, r_redir;
    logic [31:0] r_tgt;

    RESET = 1'b1;
    bus.IMEM_BUSYWAIT   = 1'b0;
    bus.DMEM_BUSYWAIT   = 1'b0;
    bus.REDIRECT        = 1'b0;
    bus.REDIRECT_TARGET = 32'h0;
    model_reset();
    apply_reset();

    // Sequential fetch from the reset vector, then wrap at the top of the address space
    idle("seq", 4);
    step("preload", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("preload.pc", bus.PC_OUT, 32'hFFFF_FFFC);
    idle("wrap", 1);
    check("wrap.pc", bus.PC_OUT, 32'h0);

    // Idle redirect at PC 8: no bubble
    idle("to8", 2);
    check("at8.pc", bus.PC_OUT, 32'h8);
    step("redir", 1'b0, 1'b0, 1'b1, 32'h40);
    check("redir.pc", bus.PC_OUT, 32'h40);
    check("redir.valid", 32'(bus.FETCH_VALID), 32'd1);
    check("redir.misalign", 32'(bus.MISALIGN_ERR), 32'd0);

    // Redirects during a stall: the latest one wins after release
    step("hold1", 1'b1, 1'b0, 1'b1, 32'h80);
    step("hold2", 1'b1, 1'b0, 1'b1, 32'h90);
    step("hold3", 1'b1, 1'b0, 1'b0, 32'h0);
    step("release", 1'b0, 1'b0, 1'b0, 32'h0);
    check("release.pc", bus.PC_OUT, 32'h90);

    // Misaligned target is truncated and flagged
    step("mis", 1'b0, 1'b0, 1'b1, 32'h23);
    check("mis.pc", bus.PC_OUT, 32'h20);
    check("mis.flag", 32'(bus.MISALIGN_ERR), 32'd1);
    idle("mis_hold", 2);

    // Timeout after TIMEOUT consecutive stall cycles, PC held
    for (int i = 0; i < 6; i++) step("tmo", 1'b0, 1'b1, 1'b0, 32'h0);
    check("tmo.flag", 32'(bus.TIMEOUT_ERR), 32'd1);
    idle("tmo_after", 2);
    check("tmo.sticky", 32'(bus.TIMEOUT_ERR), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r_busy_i = ($urandom_range(0, 9) < 2);
      r_busy_d = ($urandom_range(0, 9) < 1);
      r_redir  = ($urandom_range(0, 3) == 0);
      r_tgt    = $urandom;
      if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
      step("rand", r_busy_i, r_busy_d, r_redir, r_tgt);
    end

    // Reset mid-stall discards the pending redirect
    apply_reset();
    check("rst.misalign", 32'(bus.MISALIGN_ERR), 32'd0);
    idle("rst_boot", 2);
    step("rst_hold", 1'b1, 1'b0, 1'b1, 32'h100);
    bus.IMEM_BUSYWAIT = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    check_all("midrst", 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    idle("post_rst", 2);
    check("post_rst.pc", bus.PC_OUT, 32'h4);

    // Counters: 5 accepts and 3 stalls from a fresh reset
    apply_reset();
    idle("cnt_boot", 1);
    idle("cnt_acc", 5);
    for (int i = 0; i < 3; i++) step("cnt_stall", 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check("cnt.retired", bus.RETIRED_COUNT, exp_cnt(32'd5));
    check("cnt.stalls",  bus.STALL_COUNT,   exp_cnt(32'd3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
